ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline buffer.
- Takes the operands and the mul/div opcode latched in ID/EX, holds the pipeline through the `stall` output (fed to the buffers' `lock` inputs) while it iterates, and writes the architectural HI/LO registers.
- MFHI/MFLO read `hi`/`lo` directly.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH

Ports:
clk  input  1  clock
rst_b  input  1  synchronous, active-high reset (1 = reset)
start  input  1  EX instruction is MULT/MULTU/DIV/DIVU
is_nop  input  1  EX slot holds a bubble; blocks start
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
rs_data  input  WIDTH  multiplicand / dividend
rt_data  input  WIDTH  multiplier / divisor
stall  output  1  lock request to IF/ID, ID/EX and PC
done  output  1  one-cycle pulse when HI/LO are being written
hi  output  WIDTH  HI register (product high half / remainder)
lo  output  WIDTH  LO register (product low half / quotient)
div_by_zero  output  1  valid with done; divisor was 0

Behaviour:
- Reset values: state IDLE, hi = 0, lo = 0, stall = 0, done = 0, div_by_zero = 0, iteration counter = 0.
- Reset is taken at any state, including mid-ITER. The operation is discarded and HI/LO clear.
- FSM has three states: IDLE, ITER, FIX.
- IDLE:
  - accept = start & ~is_nop.
  - stall = accept, combinational, in the same cycle.
  - On accept, at the clock edge:
    - capture op;
    - capture |rs_data| and |rt_data| for signed ops, raw values for unsigned ops;
    - capture the result-sign bits;
    - record divisor == 0;
    - clear the accumulator; counter = 0; go to ITER.
- ITER:
  - stall = 1.
  - One step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter increments each cycle. After WIDTH cycles (counter == WIDTH-1 at the edge), go to FIX.
- FIX:
  - stall = 0, done = 1.
  - Sign correction is combinational from the accumulator; hi/lo load at the closing edge; go to IDLE.
  - `start` is ignored in FIX, because the same instruction is still in EX while the buffers advance on this edge.
- Latency: the accept cycle is cycle 0.
  - stall is high during cycles 0..WIDTH (WIDTH+1 cycles).
  - done is high in cycle WIDTH+1.
  - New hi/lo are visible from cycle WIDTH+2.
- Multiply:
  - Full 2*WIDTH-bit product; hi = upper half, lo = lower half.
  - MULT negates the 2*WIDTH product when the operand signs differ.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder.
  - DIV: quotient sign = sign(rs) ^ sign(rt); remainder sign = sign(rs).
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0, div_by_zero = 0.
- Divide by zero (DIV or DIVU):
  - Latency is unchanged.
  - hi = original rs_data, lo = all ones, div_by_zero = 1 during done.
- div_by_zero is 0 outside done and for multiplies.
- hi/lo are unchanged except in the FIX cycle's closing edge or on reset.
- All arithmetic is internal to the block. The counter is ceil(log2(WIDTH))+1 bits and never wraps during an operation.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> stall high exactly 33 cycles; done in cycle 33; hi = 0xFFFFFFFE, lo = 0x00000001 from cycle 34.
- MULT 0xFFFFFFFD (-3) * 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; then MULT 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
- DIVU 100 / 7 -> lo = 14, hi = 2.
- DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_by_zero = 0.
- DIVU 5 / 0 -> hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1 only in the done cycle.
- Assert rst_b in ITER cycle 10 -> next cycle stall = 0, hi = lo = 0, no done pulse.
- start = 1 with is_nop = 1 -> stall stays 0 and hi/lo are unchanged.
- start held high through FIX -> no second launch; stall = 0 in the cycle after done.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: one shift-add or restoring
// shift-subtract step per cycle, stalling the pipeline and writing HI/LO.
module ex_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic             is_nop,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned AW = 2 * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic [WIDTH-1:0] abs_rs, abs_rt;
   logic [WIDTH-1:0] acc_hi, acc_lo;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;
   logic [AW-1:0]    prod_neg;

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_div_d    = is_div_q;
      opb_d       = opb_q;
      acc_d       = acc_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      dz_d        = dz_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      stall       = 1'b0;
      done        = 1'b0;
      div_by_zero = 1'b0;

      abs_rs   = (op[0] && rs_data[WIDTH-1]) ? -rs_data : rs_data;
      abs_rt   = (op[0] && rt_data[WIDTH-1]) ? -rt_data : rt_data;
      acc_hi   = acc_q[AW-1:WIDTH];
      acc_lo   = acc_q[WIDTH-1:0];
      mul_sum  = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      rem_sh   = {acc_hi, acc_q[WIDTH-1]};
      // Only used when rem_sh >= divisor, so the result always fits in WIDTH bits.
      rem_sub  = rem_sh[WIDTH-1:0] - opb_q;
      prod_neg = -acc_q;

      case (state_q)
         S_IDLE: begin
            if (start && !is_nop) begin
               stall    = 1'b1;
               is_div_d = op[1];
               opb_d    = abs_rt;
               acc_d    = {{WIDTH{1'b0}}, abs_rs};
               qneg_d   = op[0] & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
               rneg_d   = op[0] & rs_data[WIDTH-1];
               dz_d     = (rt_data == '0);
               cnt_d    = '0;
               state_d  = S_ITER;
            end
         end
         S_ITER: begin
            stall = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (is_div_q) begin
               if (rem_sh >= {1'b0, opb_q}) acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
               else                         acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            // Same instruction still in EX here, so start is deliberately not examined.
            done        = 1'b1;
            div_by_zero = is_div_q & dz_q;
            if (is_div_q) begin
               hi_d = rneg_q ? -acc_hi : acc_hi;
               lo_d = dz_q ? {WIDTH{1'b1}} : (qneg_q ? -acc_lo : acc_lo);
            end else begin
               {hi_d, lo_d} = qneg_q ? prod_neg : acc_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, arithmetic corner cases,
// divide-by-zero, bubble blocking, start held through FIX and mid-op reset.
module tb_ex_muldiv_unit;

   logic        clk;
   logic        rst_b;
   logic        start;
   logic        is_nop;
   logic [1:0]  op_r;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int total;
   int bad;
   logic [31:0] prev_hi;
   logic [31:0] prev_lo;

   ex_muldiv_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .start       (start),
      .is_nop      (is_nop),
      .op          (op_r),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .stall       (stall),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_b = 1'b1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (stall !== 1'b0)       begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
      total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", div_by_zero); end
      total++; if (hi !== 32'h0)         begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
      total++; if (lo !== 32'h0)         begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
      @(posedge clk); #1;
      rst_b = 1'b0;
      prev_hi = 32'h0;
      prev_lo = 32'h0;
   endtask

   // Launch one op in cycle 0 and check stall count, done timing, dz and HI/LO.
   task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz, input logic hold);
      int stall_cnt;
      int done_cyc;
      stall_cnt = 0;
      done_cyc  = -1;
      @(posedge clk); #1;
      start = 1'b1; is_nop = 1'b0; op_r = o; rs_data = a; rt_data = b;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (stall) stall_cnt++;
         if (done && done_cyc < 0) begin
            done_cyc = c;
            total++; if (div_by_zero !== exp_dz) begin bad++; $display("FAIL %s_dz got=%b want=%b", nm, div_by_zero, exp_dz); end
            total++; if (hi !== prev_hi) begin bad++; $display("FAIL %s_hi_early got=%h want=%h", nm, hi, prev_hi); end
            total++; if (lo !== prev_lo) begin bad++; $display("FAIL %s_lo_early got=%h want=%h", nm, lo, prev_lo); end
         end else begin
            total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL %s_dz_outside c=%0d got=%b want=0", nm, c, div_by_zero); end
         end
         @(posedge clk); #1;
         if (!hold || done_cyc >= 0) start = 1'b0;
         if (done_cyc >= 0) break;
      end
      start = 1'b0;
      total++; if (done_cyc !== 33) begin bad++; $display("FAIL %s_done_cycle got=%0d want=33", nm, done_cyc); end
      total++; if (stall_cnt !== 33) begin bad++; $display("FAIL %s_stall_cycles got=%0d want=33", nm, stall_cnt); end
      @(negedge clk);
      total++; if (hi !== exp_hi) begin bad++; $display("FAIL %s_hi got=%h want=%h", nm, hi, exp_hi); end
      total++; if (lo !== exp_lo) begin bad++; $display("FAIL %s_lo got=%h want=%h", nm, lo, exp_lo); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s_stall_after got=%b want=0", nm, stall); end
      prev_hi = exp_hi;
      prev_lo = exp_lo;
   endtask

   task automatic test_multu();
      run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
   endtask

   task automatic test_mult();
      run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
      run_op("mult_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_div();
      run_op("divu",      2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
      run_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
      run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
   endtask

   task automatic test_div_zero();
      run_op("divu_zero", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op("div_zero",  2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
   endtask

   task automatic test_nop_blocked();
      @(posedge clk); #1;
      start = 1'b1; is_nop = 1'b1; op_r = 2'b00; rs_data = 32'd9; rt_data = 32'd9;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++; if (stall !== 1'b0) begin bad++; $display("FAIL nop_stall c=%0d got=%b want=0", c, stall); end
         @(posedge clk); #1;
      end
      start = 1'b0; is_nop = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         total++; if (done !== 1'b0) begin bad++; $display("FAIL nop_done c=%0d got=%b want=0", c, done); end
      end
      total++; if (hi !== prev_hi) begin bad++; $display("FAIL nop_hi got=%h want=%h", hi, prev_hi); end
      total++; if (lo !== prev_lo) begin bad++; $display("FAIL nop_lo got=%h want=%h", lo, prev_lo); end
   endtask

   task automatic test_start_held();
      run_op("held", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++; if (stall !== 1'b0) begin bad++; $display("FAIL held_relaunch_stall c=%0d got=%b want=0", c, stall); end
         total++; if (done !== 1'b0)  begin bad++; $display("FAIL held_relaunch_done c=%0d got=%b want=0", c, done); end
      end
   endtask

   task automatic test_reset_mid_iter();
      run_op("pre_rst", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
      @(posedge clk); #1;
      start = 1'b1; is_nop = 1'b0; op_r = 2'b00; rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      @(negedge clk);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL rstmid_stall_before got=%b want=1", stall); end
      rst_b = 1'b1;
      @(posedge clk); #1;
      rst_b = 1'b0;
      @(negedge clk);
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b want=0", stall); end
      total++; if (hi !== 32'h0)   begin bad++; $display("FAIL rstmid_hi got=%h want=0", hi); end
      total++; if (lo !== 32'h0)   begin bad++; $display("FAIL rstmid_lo got=%h want=0", lo); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done c=%0d got=%b want=0", c, done); end
      end
      prev_hi = 32'h0;
      prev_lo = 32'h0;
      run_op("post_rst", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
   endtask

   initial begin
      total = 0; bad = 0;
      rst_b = 1'b1; start = 1'b0; is_nop = 1'b0; op_r = 2'b00;
      rs_data = 32'h0; rt_data = 32'h0;
      prev_hi = 32'h0; prev_lo = 32'h0;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_div_zero();
      test_nop_blocked();
      test_start_held();
      test_reset_mid_iter();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
